cpu_fetch: RTL and testbench

Instruction fetch unit for the moxie core: the producer that fills the instruction FIFO. It issues 32-bit Wishbone-classic reads to instruction memory, realigns the fetch stream for halfword-aligned branch targets, and pushes big-endian 32-bit words into the FIFO whenever that FIFO can accept a full word. It also restarts fetching on a redirect and flushes the FIFO.

---
 rtl/moxie_pkg.sv | 8 +
 rtl/cpu_fetch_align.sv | 37 +++
 rtl/cpu_fetch.sv | 58 +++++
 tb/tb_cpu_fetch.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/moxie_pkg.sv
// moxie_pkg: shared fetch-state encoding, reset vector default and bus widths
package moxie_pkg;
  localparam int DATA_W = 32;
  localparam int HALF_W = 16;
  localparam logic [DATA_W-1:0] ADR_MASK = 32'hFFFF_FFFC;
  localparam logic [DATA_W-1:0] RESET_VECTOR_DEF = 32'h0000_1000;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_t;
endpackage

// File: rtl/cpu_fetch_align.sv
// cpu_fetch_align: realigns the captured word stream around halfword-aligned starts
module cpu_fetch_align import moxie_pkg::*; #(
  parameter logic MIS_RESET = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              clear_mis_i,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic              write_en_o,
  output logic [DATA_W-1:0] data_o
);
  logic mis;
  logic held;
  logic [HALF_W-1:0] hold;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      mis <= MIS_RESET;
      held <= 1'b0;
      hold <= '0;
      write_en_o <= 1'b0;
      data_o <= '0;
    end else if (clear_i) begin
      mis <= clear_mis_i;
      held <= 1'b0;
      write_en_o <= 1'b0;
    end else begin
      write_en_o <= cap_i && (!mis || held);
      if (cap_i) begin
        held <= mis;
        hold <= dat_i[HALF_W-1:0];
        if (!mis || held) data_o <= mis ? {hold, dat_i[DATA_W-1:HALF_W]} : dat_i;
      end
    end
  end
endmodule

// File: rtl/cpu_fetch.sv
// cpu_fetch: single-outstanding Wishbone instruction fetcher feeding the instruction FIFO
module cpu_fetch import moxie_pkg::*; #(
  parameter logic [DATA_W-1:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic [DATA_W-1:0] imem_adr_o,
  output logic              imem_cyc_o,
  output logic              imem_stb_o,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] imem_dat_i,
  input  logic              full_i,
  output logic              write_en_o,
  output logic [DATA_W-1:0] data_o,
  output logic              flush_o,
  input  logic              branch_i,
  input  logic [DATA_W-1:0] branch_target_i
);
  fetch_state_t state;
  logic [DATA_W-1:0] fetch_pc;
  logic cap;
  assign cap = state == FETCH && imem_ack_i && !branch_i;
  assign imem_stb_o = imem_cyc_o;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      fetch_pc <= RESET_VECTOR & ADR_MASK;
      imem_adr_o <= RESET_VECTOR & ADR_MASK;
      imem_cyc_o <= 1'b0;
      flush_o <= 1'b0;
    end else begin
      flush_o <= branch_i;
      fetch_pc <= branch_i ? branch_target_i & ADR_MASK : cap ? fetch_pc + 32'd4 : fetch_pc;
      if (state == IDLE) begin
        if (!full_i && !branch_i) begin
          state <= FETCH;
          imem_cyc_o <= 1'b1;
          imem_adr_o <= fetch_pc;
        end
      end else if (imem_ack_i) begin
        state <= IDLE;
        imem_cyc_o <= 1'b0;
      end else if (branch_i) begin
        state <= DRAIN;
      end
    end
  end
  cpu_fetch_align #(.MIS_RESET(RESET_VECTOR[1])) u_align (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clear_i(branch_i),
    .clear_mis_i(branch_target_i[1]),
    .cap_i(cap),
    .dat_i(imem_dat_i),
    .write_en_o(write_en_o),
    .data_o(data_o)
  );
endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: randomized bench checking cpu_fetch against a halfword-stream reference model
module tb_cpu_fetch;
  localparam logic [31:0] RV = 32'h0000_1000;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic [31:0] imem_adr_o;
  logic imem_cyc_o, imem_stb_o;
  logic imem_ack_i = 1'b0;
  logic [31:0] imem_dat_i = '0;
  logic full_i = 1'b0;
  logic write_en_o;
  logic [31:0] data_o;
  logic flush_o;
  logic branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  int checks = 0;
  int failures = 0;
  always #5 clk_i = ~clk_i;
  cpu_fetch dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_adr_o(imem_adr_o), .imem_cyc_o(imem_cyc_o), .imem_stb_o(imem_stb_o),
    .imem_ack_i(imem_ack_i), .imem_dat_i(imem_dat_i),
    .full_i(full_i), .write_en_o(write_en_o), .data_o(data_o), .flush_o(flush_o),
    .branch_i(branch_i), .branch_target_i(branch_target_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  logic [31:0] ovr [logic [31:0]];
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return ovr.exists(w) ? ovr[w] : (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic [15:0] half(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word(a);
    return a[1] ? w[15:0] : w[31:16];
  endfunction
  function automatic logic [31:0] word_at(input logic [31:0] b, input int k);
    logic [31:0] a;
    a = b + 32'(4 * k);
    return {half(a), half(a + 32'd2)};
  endfunction
  logic m_open, m_just, m_taint, m_we, m_flush;
  logic [31:0] m_fetch, m_base, m_data, m_adr;
  int m_n, wcnt, lat;
  task automatic model_reset();
    m_open = 0; m_just = 0; m_taint = 0; m_we = 0; m_flush = 0;
    m_fetch = RV & ~32'd3; m_base = RV; m_n = 0; m_adr = '0;
  endtask
  task automatic step(input logic r, input logic b, input logic [31:0] t, input logic f, input logic b_on_ack);
    logic a, br, useful, nxt;
    check("cyc", imem_cyc_o, m_open);
    check("stb", imem_stb_o, m_open);
    check("flush", flush_o, m_flush);
    check("write_en", write_en_o, m_we);
    if (m_we) check("data", data_o, m_data);
    if (m_open) check("adr", imem_adr_o, m_adr);
    a = 0;
    if (m_open) begin
      if (m_just) wcnt = lat >= 0 ? lat : int'($urandom_range(0, 3));
      a = wcnt == 0;
      if (!a) wcnt--;
    end
    if (!r) a = 0;
    br = b_on_ack ? a : b;
    imem_ack_i = a;
    imem_dat_i = a ? mem_word(imem_adr_o) : $urandom;
    rst_i = r; branch_i = br; branch_target_i = t; full_i = f;
    if (!r) begin
      model_reset();
      return;
    end
    m_flush = br;
    m_we = 0;
    useful = m_open && a && !m_taint && !br;
    if (useful) begin
      m_n++;
      m_fetch = m_fetch + 32'd4;
      if (!m_base[1] || m_n >= 2) begin
        m_we = 1;
        m_data = word_at(m_base, m_base[1] ? m_n - 2 : m_n - 1);
      end
    end
    nxt = m_open ? !a : (!f && !br);
    if (m_open && br && !a) m_taint = 1;
    if (br) begin
      m_base = t; m_fetch = t & ~32'd3; m_n = 0;
    end
    m_just = nxt && !m_open;
    if (m_just) begin
      m_taint = 0;
      m_adr = m_fetch;
    end
    m_open = nxt;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      step(1, 0, 32'h0, 0, 0);
    end
  endtask
  task automatic go(input logic b, input logic [31:0] t, input logic f, input logic bo);
    @(negedge clk_i);
    step(1, b, t, f, bo);
  endtask
  initial begin
    logic [31:0] t;
    ovr[32'h1000] = 32'h0102_0304;
    ovr[32'h1004] = 32'h0506_0708;
    ovr[32'h2000] = 32'hAAAA_1111;
    ovr[32'h2004] = 32'h2222_3333;
    lat = 0;
    repeat (2) @(negedge clk_i);
    model_reset();
    check("rst_adr", imem_adr_o, 32'h0000_1000);
    check("rst_data", data_o, 32'h0);
    @(negedge clk_i);
    step(0, 0, 32'h0, 0, 0);
    run(8);
    for (int i = 0; i < 5; i++) go(0, 32'h0, 1, 0);
    run(4);
    go(1, 32'h2000, 0, 0);
    run(6);
    go(1, 32'h2002, 0, 0);
    run(8);
    lat = 3;
    go(1, 32'h1008, 0, 0);
    run(1);
    go(1, 32'h3000, 0, 0);
    run(10);
    lat = 2;
    run(2);
    for (int i = 0; i < 6; i++) go(0, 32'h4000, 0, 1);
    run(6);
    lat = -1;
    for (int i = 0; i < 4000; i++) begin
      t = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | ($urandom & 32'hE)) : ($urandom & ~32'd1);
      @(negedge clk_i);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 15) == 0, t,
           $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end
    run(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
